gg_vector: RTL and testbench
============================

Name: gg_vector

Overview:
- Vectoring-mode CORDIC stage of the QR factorization datapath. Sits directly upstream of the Givens rotation (rotation-mode) stage.
- For each column it holds a pivot x and annihilates each incoming sub-element y against it. It emits 3 rotation-direction bits per cycle over 4 cycles (12 iterations) for the downstream rotation stage.
- At column end it outputs the gain-compensated pivot magnitude r.

Parameters:
- DATA_W, 13, external sample width (signed).
- BIT_W, 26, internal accumulator width.
- FRAC_SHIFT, 4, left shift applied on entry and undone on exit.
- ITER_PER_CYC, 3, CORDIC iterations per clock.
- N_ITER, 12, total iterations per element (4 cycles).
- K_GAIN, 155, CORDIC gain compensation (Q1.8, ~0.6055).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- in_valid  in  1  data_in/first/last_in valid.
- in_ready  out  1  high when the block accepts a sample.
- data_in  in  DATA_W  signed sample.
- first  in  1  sample is a column pivot (x).
- last_in  in  1  sample is the last element of its column.
- di_out  out  3  direction bits; bit j = iteration cnt*3+j.
- di_valid  out  1  di_out valid.
- first_out  out  1  high with the first di_valid beat of each column.
- last_out  out  1  high with the final di_valid beat of the column's last element.
- r_out  out  DATA_W  signed pivot magnitude.
- r_valid  out  1  one-cycle pulse, r_out valid.

Behaviour:
- Reset values: all outputs 0 except in_ready=1. State returns to IDLE, cnt=0, and x_acc/y_acc are cleared.
- States: IDLE and ROT. in_ready = (state==IDLE). An accept is in_valid && in_ready; in_valid while busy is ignored.
- IDLE, accept with first=1:
  - x_acc <= data_in<<<FRAC_SHIFT.
  - If last_in is also 1: r_out <= data_in and r_valid pulses next cycle.
  - State stays IDLE.
- IDLE, accept with first=0:
  - y_acc <= data_in<<<FRAC_SHIFT, cnt<=0, state to ROT.
  - Latch last_in and whether this is the first y of the column.
- ROT, each cycle, three chained iterations i = cnt*3+j (j=0..2):
  - d_j = sign bit of y before iteration i.
  - d=0: x'=x+(y>>>i), y'=y-(x>>>i).
  - d=1: x'=x-(y>>>i), y'=y+(x>>>i).
  - All shifts are arithmetic at BIT_W.
  - x_acc/y_acc register the third iteration's result.
  - di_out <= {d2,d1,d0} and di_valid <= 1, registered (one cycle after the ROT cycle).
- Timing: accept at edge T gives ROT cycles at cnt 0..3 and di_valid high for edges T+2..T+5 (4 beats). first_out and last_out mark the first and last beats per the port definitions.
- End of cnt==3:
  - x_acc <= (x12*K_GAIN)>>>8.
  - If latched last: r_out <= sat(x_scaled>>>FRAC_SHIFT) and r_valid pulses.
  - State to IDLE in either case. Throughput is one y per 5 cycles.
- Saturation: clamp r_out to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- y without a preceding first uses the current x_acc (0 after reset). This is legal; the rotation is degenerate.
- Convergence is guaranteed for x_acc>=0 only, unless the optional feature below is enabled.
- Reset mid-ROT: immediate abort; no partial di or r output after release.

Optional Feature:
- Macro GG_PREROT_EN.
- Defined: on a first sample with data_in<0, x_acc loads the negated value. A sticky flip flag is asserted and presented on an extra output flip_out, qualified with first_out, so the downstream stage negates the column's first row. A first&&last single element gives r_out=|data_in|.
- Undefined: x is loaded as-is, flip_out does not exist, and negative pivots are passed through unrotated.

Decomposition:
- Package qr_cordic_pkg: DATA_W, BIT_W, FRAC_SHIFT, ITER_PER_CYC, N_ITER, K_GAIN, and the state enum {IDLE, ROT}.
- Sub-module cordic_vec_step: one combinational iteration (x, y, shift index in; x', y', d out), instantiated ITER_PER_CYC times.

Test Plan:
- first x=300, then y=400 with last: di_valid for 4 beats; beat 0 bit0=0; r_out = 500±2 with one r_valid pulse.
- first x=100, then y=0 with last: r_out = 100±2.
- first x=300, y=400, then y=1200 with last: 8 di beats; last_out only on beat 8; r_out = 1300±3.
- first&&last x=-77: without GG_PREROT_EN r_out=-77; with it r_out=77 and flip_out=1.
- in_valid held high continuously with y stream: accepts spaced exactly 5 cycles; held samples are ignored while in_ready=0.
- reset low at cnt=2: all outputs 0 and in_ready=1 after release; no stray di_valid or r_valid.

Source files
------------

// File: rtl/qr_cordic_pkg.sv
// Shared constants, FSM states and helpers for the QR vectoring CORDIC.
// Sample/accumulator conversion and r_out saturation live here.
package qr_cordic_pkg;

  localparam int DATA_W       = 13;
  localparam int BIT_W        = 26;
  localparam int FRAC_SHIFT   = 4;
  localparam int ITER_PER_CYC = 3;
  localparam int N_ITER       = 12;
  localparam int K_GAIN       = 155;
  localparam int K_FRAC       = 8;
  localparam int SH_W         = 5;
  localparam int N_CYC        = N_ITER / ITER_PER_CYC;

  localparam logic signed [BIT_W-1:0] R_MAX =
    BIT_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [BIT_W-1:0] R_MIN =
    BIT_W'(-(2 ** (DATA_W - 1)));

  typedef enum logic {
    IDLE,
    ROT
  } state_t;

  function automatic logic signed [BIT_W-1:0] sext(
    input logic signed [DATA_W-1:0] d
  );
    return {{(BIT_W - DATA_W){d[DATA_W-1]}}, d};
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_r(
    input logic signed [BIT_W-1:0] v
  );
    if (v > R_MAX)
      return R_MAX[DATA_W-1:0];
    else if (v < R_MIN)
      return R_MIN[DATA_W-1:0];
    else
      return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// One combinational vectoring iteration: rotate toward y=0.
// d is the sign of the incoming y and selects the rotation sense.
module cordic_vec_step
  import qr_cordic_pkg::*;
(
  input  logic signed [BIT_W-1:0] x,
  input  logic signed [BIT_W-1:0] y,
  input  logic [SH_W-1:0]         sh,
  output logic signed [BIT_W-1:0] x_n,
  output logic signed [BIT_W-1:0] y_n,
  output logic                    d
);

  logic signed [BIT_W-1:0] xs;
  logic signed [BIT_W-1:0] ys;

  assign d   = y[BIT_W-1];
  assign xs  = x >>> sh;
  assign ys  = y >>> sh;
  assign x_n = d ? (x - ys) : (x + ys);
  assign y_n = d ? (y + xs) : (y - xs);

endmodule

// File: rtl/gg_vector.sv
// Vectoring CORDIC stage: per-column pivot, 3 iterations per clock.
// Optional pivot pre-rotation under macro GG_PREROT_EN.
module gg_vector
  import qr_cordic_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     first,
  input  logic                     last_in,
  output logic [ITER_PER_CYC-1:0]  di_out,
  output logic                     di_valid,
  output logic                     first_out,
  output logic                     last_out,
  output logic signed [DATA_W-1:0] r_out,
  output logic                     r_valid
`ifdef GG_PREROT_EN
  ,
  output logic                     flip_out
`endif
);

  localparam logic [1:0] CNT_LAST = 2'(N_CYC - 1);
  localparam logic signed [BIT_W+9:0] KG =
    (BIT_W + 10)'(K_GAIN);

  state_t                  state;
  logic [1:0]              cnt;
  logic signed [BIT_W-1:0] x_acc;
  logic signed [BIT_W-1:0] y_acc;
  logic                    last_q;
  logic                    first_q;
  logic                    col_start;

  logic signed [BIT_W-1:0] xc [ITER_PER_CYC+1];
  logic signed [BIT_W-1:0] yc [ITER_PER_CYC+1];
  logic [SH_W-1:0]         sh [ITER_PER_CYC];
  logic [ITER_PER_CYC-1:0] dv;

  logic signed [BIT_W+9:0] xe;
  logic signed [BIT_W+9:0] prod;
  logic signed [BIT_W-1:0] x_scaled;
  logic signed [BIT_W-1:0] r_acc;
  logic signed [BIT_W-1:0] piv;

  assign in_ready = (state == IDLE);

`ifdef GG_PREROT_EN
  logic neg_in;
  assign neg_in = data_in[DATA_W-1];
  assign piv    = neg_in ? -sext(data_in) : sext(data_in);
`else
  assign piv    = sext(data_in);
`endif

  assign xc[0] = x_acc;
  assign yc[0] = y_acc;

  for (genvar j = 0; j < ITER_PER_CYC; j++) begin : g_step
    assign sh[j] = SH_W'(cnt) * SH_W'(ITER_PER_CYC) + SH_W'(j);
    cordic_vec_step u_step (
      .x   (xc[j]),
      .y   (yc[j]),
      .sh  (sh[j]),
      .x_n (xc[j+1]),
      .y_n (yc[j+1]),
      .d   (dv[j])
    );
  end

  assign xe = {{10{xc[ITER_PER_CYC][BIT_W-1]}},
               xc[ITER_PER_CYC]};
  assign prod     = xe * KG;
  assign x_scaled = BIT_W'(prod >>> K_FRAC);
  assign r_acc    = x_scaled >>> FRAC_SHIFT;

  // Accept, iterate and emit direction/magnitude results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      x_acc     <= '0;
      y_acc     <= '0;
      last_q    <= 1'b0;
      first_q   <= 1'b0;
      col_start <= 1'b0;
      di_out    <= '0;
      di_valid  <= 1'b0;
      first_out <= 1'b0;
      last_out  <= 1'b0;
      r_out     <= '0;
      r_valid   <= 1'b0;
`ifdef GG_PREROT_EN
      flip_out  <= 1'b0;
`endif
    end else begin
      di_valid  <= 1'b0;
      first_out <= 1'b0;
      last_out  <= 1'b0;
      r_valid   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (first) begin
              x_acc     <= piv <<< FRAC_SHIFT;
              col_start <= 1'b1;
`ifdef GG_PREROT_EN
              flip_out  <= neg_in;
`endif
              if (last_in) begin
                r_out   <= sat_r(piv);
                r_valid <= 1'b1;
              end
            end else begin
              y_acc     <= sext(data_in) <<< FRAC_SHIFT;
              cnt       <= '0;
              state     <= ROT;
              last_q    <= last_in;
              first_q   <= col_start;
              col_start <= 1'b0;
            end
          end
        end
        ROT: begin
          di_out    <= dv;
          di_valid  <= 1'b1;
          first_out <= first_q && (cnt == 2'd0);
          last_out  <= last_q && (cnt == CNT_LAST);
          y_acc     <= yc[ITER_PER_CYC];
          if (cnt == CNT_LAST) begin
            x_acc <= x_scaled;
            cnt   <= '0;
            state <= IDLE;
            if (last_q) begin
              r_out   <= sat_r(r_acc);
              r_valid <= 1'b1;
            end
          end else begin
            x_acc <= xc[ITER_PER_CYC];
            cnt   <= cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gg_vector.sv
// Bench for gg_vector: directed columns, streaming, reset abort and
// random columns against a real-valued magnitude/direction model.
module tb_gg_vector;
  import qr_cordic_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] data_in = '0;
  logic                     first = 1'b0;
  logic                     last_in = 1'b0;
  logic [2:0]               di_out;
  logic                     di_valid;
  logic                     first_out;
  logic                     last_out;
  logic signed [DATA_W-1:0] r_out;
  logic                     r_valid;
`ifdef GG_PREROT_EN
  logic                     flip_out;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  real g_col;

  logic [2:0] di_q[$];
  bit         fo_q[$];
  bit         lo_q[$];
  int         dc_q[$];
  int         r_q[$];

  gg_vector dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .first     (first),
    .last_in   (last_in),
    .di_out    (di_out),
    .di_valid  (di_valid),
    .first_out (first_out),
    .last_out  (last_out),
    .r_out     (r_out),
    .r_valid   (r_valid)
`ifdef GG_PREROT_EN
    ,
    .flip_out  (flip_out)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (di_valid) begin
      di_q.push_back(di_out);
      fo_q.push_back(first_out);
      lo_q.push_back(last_out);
      dc_q.push_back(cyc);
    end
    if (r_valid) r_q.push_back(int'(r_out));
  end

  task automatic clear_q();
    di_q.delete();
    fo_q.delete();
    lo_q.delete();
    dc_q.delete();
    r_q.delete();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bit f, input bit l, input int d,
                      output int acc);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step(1);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    first = f;
    last_in = l;
    data_in = DATA_W'(d);
    step(1);
    acc = cyc;
    in_valid = 1'b0;
    first = 1'b0;
    last_in = 1'b0;
  endtask

  task automatic run_column(input int x, input int ny,
                            input int y0, input int y1,
                            input int y2, output int acc0);
    int ys[3];
    int a;
    ys = '{y0, y1, y2};
    acc0 = 0;
    clear_q();
    send(1'b1, ny == 0, x, a);
    for (int k = 0; k < ny; k++) begin
      send(1'b0, k == ny - 1, ys[k], a);
      if (k == 0) acc0 = a;
    end
    step(8);
  endtask

  function automatic real model(input int x, input int ny,
                                input int y0, input int y1,
                                input int y2);
    int ys[3];
    real m;
    ys = '{y0, y1, y2};
    m = real'(x);
    for (int k = 0; k < ny; k++)
      m = $sqrt(m * m + real'(ys[k]) * real'(ys[k])) * g_col;
    return m;
  endfunction

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic int mask_of(input int which);
    int m;
    m = 0;
    for (int i = 0; i < di_q.size() && i < 30; i++)
      if ((which == 0) ? fo_q[i] : lo_q[i]) m |= (1 << i);
    return m;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    step(2);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready: got %0b want 1", in_ready);
    end
    checks++;
    if (di_valid !== 1'b0 || di_out !== 3'd0) begin
      errors++;
      $display("FAIL rst_di: got v=%0b d=%0d want 0 0",
               di_valid, di_out);
    end
    checks++;
    if (r_valid !== 1'b0 || r_out !== '0) begin
      errors++;
      $display("FAIL rst_r: got v=%0b r=%0d want 0 0",
               r_valid, r_out);
    end
    checks++;
    if (first_out !== 1'b0 || last_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: got f=%0b l=%0b want 0 0",
               first_out, last_out);
    end
    reset = 1'b1;
    step(2);
  endtask

  task automatic test_basic();
    int acc;
    int r;
    real m;
    run_column(300, 1, 400, 0, 0, acc);
    m = model(300, 1, 400, 0, 0);
    checks++;
    if (di_q.size() !== 4) begin
      errors++;
      $display("FAIL basic_beats: got %0d want 4", di_q.size());
    end
    checks++;
    if (dc_q.size() != 4 || dc_q[0] != acc + 1 || dc_q[3] != acc + 4)
    begin
      errors++;
      $display("FAIL basic_timing: got first=%0d last=%0d want %0d %0d",
               dc_q.size() > 0 ? dc_q[0] : -1,
               dc_q.size() > 3 ? dc_q[3] : -1, acc + 1, acc + 4);
    end
    checks++;
    if (di_q.size() == 0 || di_q[0][0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_d0: got %0d want bit0=0",
               di_q.size() > 0 ? di_q[0] : 3'd7);
    end
    checks++;
    if (mask_of(0) != 1 || mask_of(1) != 8) begin
      errors++;
      $display("FAIL basic_marks: got f=%0h l=%0h want 1 8",
               mask_of(0), mask_of(1));
    end
    checks++;
    if (r_q.size() != 1) begin
      errors++;
      $display("FAIL basic_rcount: got %0d want 1", r_q.size());
    end
    r = (r_q.size() > 0) ? r_q[0] : -9999;
    checks++;
    if (r < 498 || r > 502) begin
      errors++;
      $display("FAIL basic_r: got %0d want 500+-2", r);
    end
    checks++;
    if (rabs(real'(r) - m) > 2.0) begin
      errors++;
      $display("FAIL basic_r_model: got %0d want %0f+-2", r, m);
    end
  endtask

  task automatic test_zero_y();
    int acc;
    int r;
    run_column(100, 1, 0, 0, 0, acc);
    r = (r_q.size() > 0) ? r_q[0] : -9999;
    checks++;
    if (di_q.size() != 4 || r_q.size() != 1) begin
      errors++;
      $display("FAIL zero_counts: got beats=%0d r=%0d want 4 1",
               di_q.size(), r_q.size());
    end
    checks++;
    if (r < 98 || r > 102) begin
      errors++;
      $display("FAIL zero_r: got %0d want 100+-2", r);
    end
  endtask

  task automatic test_two_elems();
    int acc;
    int r;
    real m;
    run_column(300, 2, 400, 1200, 0, acc);
    m = model(300, 2, 400, 1200, 0);
    r = (r_q.size() > 0) ? r_q[0] : -9999;
    checks++;
    if (di_q.size() != 8) begin
      errors++;
      $display("FAIL two_beats: got %0d want 8", di_q.size());
    end
    checks++;
    if (mask_of(1) != 'h80 || mask_of(0) != 'h01) begin
      errors++;
      $display("FAIL two_marks: got l=%0h f=%0h want 80 01",
               mask_of(1), mask_of(0));
    end
    checks++;
    if (r_q.size() != 1 || rabs(real'(r) - m) > 3.0) begin
      errors++;
      $display("FAIL two_r: got %0d (n=%0d) want %0f+-3",
               r, r_q.size(), m);
    end
  endtask

  task automatic test_single_neg();
    int a;
    int want;
`ifdef GG_PREROT_EN
    want = 77;
`else
    want = -77;
`endif
    clear_q();
    send(1'b1, 1'b1, -77, a);
    step(3);
    checks++;
    if (di_q.size() != 0 || r_q.size() != 1) begin
      errors++;
      $display("FAIL neg_counts: got beats=%0d r=%0d want 0 1",
               di_q.size(), r_q.size());
    end
    checks++;
    if (r_q.size() == 0 || r_q[0] != want) begin
      errors++;
      $display("FAIL neg_r: got %0d want %0d",
               r_q.size() > 0 ? r_q[0] : -9999, want);
    end
`ifdef GG_PREROT_EN
    checks++;
    if (flip_out !== 1'b1) begin
      errors++;
      $display("FAIL neg_flip: got %0b want 1", flip_out);
    end
`endif
  endtask

  task automatic test_stream();
    int a;
    int acc_q[$];
    clear_q();
    send(1'b1, 1'b0, 200, a);
    clear_q();
    in_valid = 1'b1;
    first = 1'b0;
    last_in = 1'b0;
    for (int c = 0; c < 32; c++) begin
      data_in = DATA_W'($urandom_range(400) - 200);
      if (in_ready) acc_q.push_back(cyc + 1);
      step(1);
    end
    in_valid = 1'b0;
    step(6);
    checks++;
    if (acc_q.size() < 6) begin
      errors++;
      $display("FAIL stream_accepts: got %0d want >=6", acc_q.size());
    end
    for (int i = 1; i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i] - acc_q[i-1] != 5) begin
        errors++;
        $display("FAIL stream_gap: got %0d want 5",
                 acc_q[i] - acc_q[i-1]);
      end
    end
    checks++;
    if (di_q.size() != 4 * acc_q.size() || r_q.size() != 0) begin
      errors++;
      $display("FAIL stream_beats: got %0d r=%0d want %0d 0",
               di_q.size(), r_q.size(), 4 * acc_q.size());
    end
    checks++;
    if (mask_of(0) != 1) begin
      errors++;
      $display("FAIL stream_first: got %0h want 1", mask_of(0));
    end
  endtask

  task automatic test_reset_mid();
    int a;
    clear_q();
    send(1'b1, 1'b0, 300, a);
    send(1'b0, 1'b1, 400, a);
    step(2);
    reset = 1'b0;
    #1;
    clear_q();
    checks++;
    if (in_ready !== 1'b1 || di_valid !== 1'b0 || r_valid !== 1'b0)
    begin
      errors++;
      $display("FAIL mid_ctl: got rdy=%0b dv=%0b rv=%0b want 1 0 0",
               in_ready, di_valid, r_valid);
    end
    checks++;
    if (r_out !== '0 || di_out !== 3'd0 || first_out !== 1'b0 ||
        last_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_data: got r=%0d d=%0d f=%0b l=%0b want 0",
               r_out, di_out, first_out, last_out);
    end
    step(2);
    reset = 1'b1;
    step(8);
    checks++;
    if (di_q.size() != 0 || r_q.size() != 0 || in_ready !== 1'b1)
    begin
      errors++;
      $display("FAIL mid_after: got beats=%0d r=%0d rdy=%0b want 0 0 1",
               di_q.size(), r_q.size(), in_ready);
    end
  endtask

  task automatic test_random();
    int x;
    int ny;
    int ys[3];
    int acc;
    int r;
    real m;
    for (int t = 0; t < 20; t++) begin
      x = int'($urandom_range(1000, 1));
      ny = int'($urandom_range(3, 1));
      for (int k = 0; k < 3; k++)
        ys[k] = int'($urandom_range(2000)) - 1000;
      run_column(x, ny, ys[0], ys[1], ys[2], acc);
      m = model(x, ny, ys[0], ys[1], ys[2]);
      r = (r_q.size() > 0) ? r_q[0] : -9999;
      checks++;
      if (di_q.size() != 4 * ny || r_q.size() != 1) begin
        errors++;
        $display("FAIL rnd_counts: got beats=%0d r=%0d want %0d 1",
                 di_q.size(), r_q.size(), 4 * ny);
      end
      checks++;
      if (rabs(real'(r) - m) > 3.0) begin
        errors++;
        $display("FAIL rnd_r: x=%0d ny=%0d got %0d want %0f+-3",
                 x, ny, r, m);
      end
      for (int k = 0; k < ny; k++) begin
        checks++;
        if (di_q.size() <= 4 * k || di_q[4*k][0] !== (ys[k] < 0)) begin
          errors++;
          $display("FAIL rnd_d0: elem %0d y=%0d got %0d want bit0=%0b",
                   k, ys[k], di_q.size() > 4 * k ? di_q[4*k] : 3'd0,
                   ys[k] < 0);
        end
      end
      checks++;
      if (mask_of(0) != 1 || mask_of(1) != (1 << (4 * ny - 1))) begin
        errors++;
        $display("FAIL rnd_marks: got f=%0h l=%0h want 1 %0h",
                 mask_of(0), mask_of(1), 1 << (4 * ny - 1));
      end
    end
  endtask

  initial begin
    real p;
    g_col = real'(K_GAIN) / 256.0;
    p = 1.0;
    for (int i = 0; i < N_ITER; i++) begin
      g_col = g_col * $sqrt(1.0 + p * p);
      p = p / 2.0;
    end
    test_reset();
    test_basic();
    test_zero_y();
    test_two_elems();
    test_single_neg();
    test_stream();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
